// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing checksum byte / CHK state).
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned ADDR_W         = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } loader_state_e;

    // Where the FSM goes once the payload is exhausted, and whether it still takes bytes there.
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e POST_PAYLOAD       = CHK;
    localparam logic          POST_PAYLOAD_READY = 1'b1;
`else
    localparam loader_state_e POST_PAYLOAD       = DONE;
    localparam logic          POST_PAYLOAD_READY = 1'b0;
`endif

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian word assembler: shifts in bytes, flags the byte that completes a word.
module loader_word_asm
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

    logic [WORD_W-9:0] shreg;
    logic [CNT_W-1:0]  cnt;

    // Word as it would be with the current byte as its least significant byte.
    assign word_c      = {shreg, byte_in};
    assign word_done_c = shift_en && (cnt == CNT_W'(BYTES_PER_WORD - 1));

    // Shift register and byte-in-word counter; clear discards a partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= word_c[WORD_W-9:0];
            cnt   <= word_done_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream, writes words to
// instruction memory and holds the processor in reset until the load completes.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err
);

    loader_state_e     state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  word_idx;
    logic [LEN_W-1:0]  len_full_c;
    logic              fire_c;
    logic              shift_c;
    logic              word_done_c;
    logic [WORD_W-1:0] word_c;

    assign fire_c     = in_valid && in_ready;
    assign shift_c    = fire_c && !start && (state == DATA);
    assign len_full_c = {len[LEN_W-1:8], in_byte};

    loader_word_asm u_word_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (start),
        .shift_en    (shift_c),
        .byte_in     (in_byte),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over the length and payload bytes of the current load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (start) begin
            csum <= '0;
        end else if (fire_c && (state == LEN_HI || state == LEN_LO || state == DATA)) begin
            csum <= csum ^ in_byte;
        end
    end
`endif

    // Load FSM with registered outputs; start from any state re-arms a fresh load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_BASE;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
            word_idx  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state     <= LEN_HI;
                in_ready  <= 1'b1;
                cpu_rst_n <= 1'b0;
                done      <= 1'b0;
                err       <= 1'b0;
                len       <= '0;
                word_idx  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        in_ready <= 1'b0;
                    end
                    LEN_HI: begin
                        if (fire_c) begin
                            len[LEN_W-1:8] <= in_byte;
                            state          <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (fire_c) begin
                            len <= len_full_c;
                            if (32'(len_full_c) > 32'(MAX_WORDS)) begin
                                state    <= ERR;
                                in_ready <= 1'b0;
                            end else if (len_full_c == '0) begin
                                state    <= POST_PAYLOAD;
                                in_ready <= POST_PAYLOAD_READY;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (word_done_c) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_BASE + 32'(word_idx) * 32'(BYTES_PER_WORD);
                            mem_wdata <= word_c;
                            word_idx  <= word_idx + LEN_W'(1);
                            if (word_idx == len - LEN_W'(1)) begin
                                state    <= POST_PAYLOAD;
                                in_ready <= POST_PAYLOAD_READY;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHK: begin
                        if (fire_c) begin
                            in_ready <= 1'b0;
                            state    <= (in_byte == csum) ? DONE : ERR;
                        end
                    end
`endif
                    DONE: begin
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end
                    ERR: begin
                        err       <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: stream-level reference model plus directed loads.
module tb_instr_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int unsigned MAXW = 256;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    instr_mem_loader #(
        .ADDR_BASE (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (stream-level) ----------------
    bit          m_active;
    int          m_cnt;
    int          m_len;
    logic [31:0] m_word;
    logic [7:0]  m_xor;
    bit          m_pend_done;
    bit          m_pend_err;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_done;
    logic        e_err;
    logic        e_cpu;

    task automatic model_reset();
        m_active    = 1'b0;
        m_cnt       = 0;
        m_len       = 0;
        m_word      = '0;
        m_xor       = '0;
        m_pend_done = 1'b0;
        m_pend_err  = 1'b0;
        e_we        = 1'b0;
        e_addr      = BASE;
        e_data      = '0;
        e_done      = 1'b0;
        e_err       = 1'b0;
        e_cpu       = 1'b0;
    endtask

    task automatic payload_end();
`ifndef LOADER_CHECKSUM_EN
        m_active    = 1'b0;
        m_pend_done = 1'b1;
`endif
    endtask

    task automatic model_step();
        logic [7:0] b;
        int         k;
        e_we = 1'b0;
        if (m_pend_done) begin
            e_done = 1'b1;
            e_cpu  = 1'b1;
            m_pend_done = 1'b0;
        end
        if (m_pend_err) begin
            e_err = 1'b1;
            e_cpu = 1'b0;
            m_pend_err = 1'b0;
        end
        if (start) begin
            m_active    = 1'b1;
            m_cnt       = 0;
            m_len       = 0;
            m_xor       = '0;
            m_pend_done = 1'b0;
            m_pend_err  = 1'b0;
            e_done      = 1'b0;
            e_err       = 1'b0;
            e_cpu       = 1'b0;
        end else if (in_valid && m_active) begin
            b = in_byte;
            m_cnt++;
            if (m_cnt == 1) begin
                m_len = 256 * int'(b);
                m_xor = m_xor ^ b;
            end else if (m_cnt == 2) begin
                m_len = m_len + int'(b);
                m_xor = m_xor ^ b;
                if (m_len > int'(MAXW)) begin
                    m_active   = 1'b0;
                    m_pend_err = 1'b1;
                end else if (m_len == 0) begin
                    payload_end();
                end
            end else if (m_cnt <= 2 + 4 * m_len) begin
                m_xor  = m_xor ^ b;
                m_word = {m_word[23:0], b};
                if ((m_cnt - 2) % 4 == 0) begin
                    k      = (m_cnt - 2) / 4 - 1;
                    e_we   = 1'b1;
                    e_addr = BASE + 32'(4 * k);
                    e_data = m_word;
                end
                if (m_cnt == 2 + 4 * m_len) payload_end();
            end else begin
                m_active = 1'b0;
                if (b == m_xor) m_pend_done = 1'b1;
                else            m_pend_err  = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle compare of every output against the model; also logs DUT writes.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("in_ready",  32'(in_ready),  32'(m_active));
                chk("mem_we",    32'(mem_we),    32'(e_we));
                chk("mem_addr",  mem_addr,       e_addr);
                chk("mem_wdata", mem_wdata,      e_data);
                chk("done",      32'(done),      32'(e_done));
                chk("err",       32'(err),       32'(e_err));
                chk("cpu_rst_n", 32'(cpu_rst_n), 32'(e_cpu));
                if (mem_we === 1'b1) begin
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_wdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send_load(input logic [31:0] words[$], input int gap, input bit csum_ok);
        logic [15:0] n;
        logic [7:0]  x;
        logic [31:0] w;
        n = 16'(words.size());
        x = n[15:8] ^ n[7:0];
        do_start();
        put(n[15:8], gap);
        put(n[7:0], gap);
        foreach (words[i]) begin
            w = words[i];
            for (int j = 3; j >= 0; j--) begin
                put(w[8*j +: 8], gap);
                x = x ^ w[8*j +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        put(csum_ok ? x : ~x, gap);
`else
        if (!csum_ok) x = ~x;
`endif
    endtask

    logic [31:0] q[$];

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = '0;
        idle(3);
        armed = 1'b1;
        idle(1);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_mem_addr",  mem_addr,       32'h0000_0100);
        chk("rst_mem_wdata", mem_wdata,      32'h0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Two-word program
        clear_log();
        q = '{32'h2008_0005, 32'h0000_000C};
        send_load(q, 0, 1'b1);
        idle(4);
        chk("t1_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("t1_addr0", log_addr[0], 32'h0000_0100);
            chk("t1_data0", log_data[0], 32'h2008_0005);
            chk("t1_addr1", log_addr[1], 32'h0000_0104);
            chk("t1_data1", log_data[1], 32'h0000_000C);
        end
        chk("t1_done", 32'(done),      32'd1);
        chk("t1_cpu",  32'(cpu_rst_n), 32'd1);

        // Single word lands at the base address
        clear_log();
        q = '{32'hDEAD_BEEF};
        send_load(q, 0, 1'b1);
        idle(4);
        chk("t2_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) chk("t2_addr0", log_addr[0], 32'h0000_0100);
        chk("t2_done", 32'(done), 32'd1);

        // Length 0x0101 exceeds MAX_WORDS
        clear_log();
        do_start();
        put(8'h01, 0);
        put(8'h01, 0);
        put(8'h55, 0);
        idle(4);
        chk("t3_err",      32'(err),       32'd1);
        chk("t3_cpu",      32'(cpu_rst_n), 32'd0);
        chk("t3_done",     32'(done),      32'd0);
        chk("t3_nwrites",  32'(log_addr.size()), 32'd0);

        // Restart after two data bytes abandons the partial word
        clear_log();
        do_start();
        put(8'h00, 0);
        put(8'h01, 0);
        put(8'h11, 0);
        put(8'h22, 0);
        q = '{32'hCAFE_F00D};
        send_load(q, 0, 1'b1);
        idle(4);
        chk("t4_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            chk("t4_addr0", log_addr[0], 32'h0000_0100);
            chk("t4_data0", log_data[0], 32'hCAFE_F00D);
        end
        chk("t4_done", 32'(done), 32'd1);

        // in_valid every other cycle over three words
        clear_log();
        q = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C};
        send_load(q, 1, 1'b1);
        idle(4);
        chk("t5_nwrites", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            chk("t5_addr0", log_addr[0], 32'h0000_0100);
            chk("t5_addr1", log_addr[1], 32'h0000_0104);
            chk("t5_addr2", log_addr[2], 32'h0000_0108);
            chk("t5_data2", log_data[2], 32'h090A_0B0C);
        end

        // Empty program
        clear_log();
        q.delete();
        send_load(q, 0, 1'b1);
        idle(4);
        chk("t6_nwrites", 32'(log_addr.size()), 32'd0);
        chk("t6_done",    32'(done), 32'd1);

        // Reset in the middle of a word
        clear_log();
        do_start();
        put(8'h00, 0);
        put(8'h01, 0);
        put(8'hAA, 0);
        put(8'hBB, 0);
        put(8'hCC, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t7_we",   32'(mem_we),   32'd0);
        chk("t7_addr", mem_addr,      32'h0000_0100);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        idle(3);
        chk("t7_nwrites", 32'(log_addr.size()), 32'd0);
        q = '{32'h1234_5678, 32'h9ABC_DEF0};
        send_load(q, 0, 1'b1);
        idle(4);
        chk("t7_nwrites2", 32'(log_addr.size()), 32'd2);
        chk("t7_done",     32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // 00^01^AA^BB^CC^DD = 0x01
        clear_log();
        do_start();
        put(8'h00, 0); put(8'h01, 0);
        put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 0); put(8'hDD, 0);
        put(8'h01, 0);
        idle(4);
        chk("t8_done", 32'(done), 32'd1);
        chk("t8_err",  32'(err),  32'd0);
        do_start();
        put(8'h00, 0); put(8'h01, 0);
        put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 0); put(8'hDD, 0);
        put(8'h45, 0);
        idle(4);
        chk("t8_bad_err",  32'(err),       32'd1);
        chk("t8_bad_cpu",  32'(cpu_rst_n), 32'd0);
        chk("t8_nwrites",  32'(log_addr.size()), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
